// File: rtl/button_events_if.sv
// button_events_if: debounced button levels in, per-channel event pulses and held level out.
interface button_events_if #(
    parameter int unsigned N_BUTTONS = 4
);
    logic [N_BUTTONS-1:0] in_i;
    logic [N_BUTTONS-1:0] press_o;
    logic [N_BUTTONS-1:0] release_o;
    logic [N_BUTTONS-1:0] long_press_o;
    logic [N_BUTTONS-1:0] repeat_o;
    logic [N_BUTTONS-1:0] held_o;
    modport master (output in_i, input press_o, release_o, long_press_o, repeat_o, held_o);
    modport slave  (input in_i, output press_o, release_o, long_press_o, repeat_o, held_o);
endinterface

// File: rtl/button_events.sv
// button_events: per-button press/release/long-press pulses and held level from debounced inputs.
// Auto-repeat pulses in the LONG state are built only when BUTTON_REPEAT_EN is defined.
module button_events #(
    parameter int unsigned N_BUTTONS     = 4,
    parameter int unsigned LONG_DELAY    = 12500000,
    parameter int unsigned REPEAT_PERIOD = 2500000
) (
    input logic clk,
    input logic rst_n,
    button_events_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;
    localparam logic [31:0] LONG_LAST = 32'(LONG_DELAY - 1);
`ifdef BUTTON_REPEAT_EN
    localparam logic [31:0] REP_LAST = 32'(REPEAT_PERIOD - 1);
`endif
    if (LONG_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("button_events: LONG_DELAY must be >= 2 and REPEAT_PERIOD >= 1");
    end
    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        state_t st_q, st_d;
        logic [31:0] cnt_q, cnt_d;
        logic prs_q, prs_d, rel_q, rel_d, lng_q, lng_d;
        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            prs_d = 1'b0;
            rel_d = 1'b0;
            lng_d = 1'b0;
            case (st_q)
                IDLE: if (bus.in_i[i]) begin
                    st_d  = PRESSED;
                    cnt_d = '0;
                    prs_d = 1'b1;
                end
                PRESSED: if (!bus.in_i[i]) begin
                    st_d  = IDLE;
                    cnt_d = '0;
                    rel_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    st_d  = LONG;
                    cnt_d = '0;
                    lng_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
                LONG: if (!bus.in_i[i]) begin
                    st_d  = IDLE;
                    cnt_d = '0;
                    rel_d = 1'b1;
                end
`ifdef BUTTON_REPEAT_EN
                else if (cnt_q != REP_LAST) begin
                    cnt_d = cnt_q + 32'd1;
                end else begin
                    cnt_d = '0;
                end
`endif
                default: st_d = IDLE;
            endcase
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q  <= IDLE;
                cnt_q <= '0;
                prs_q <= 1'b0;
                rel_q <= 1'b0;
                lng_q <= 1'b0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
                prs_q <= prs_d;
                rel_q <= rel_d;
                lng_q <= lng_d;
            end
        end
`ifdef BUTTON_REPEAT_EN
        // Repeat fires on the terminal count while the button is still held.
        logic rpt_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) rpt_q <= 1'b0;
            else rpt_q <= (st_q == LONG) && bus.in_i[i] && (cnt_q == REP_LAST);
        end
        assign bus.repeat_o[i] = rpt_q;
`else
        assign bus.repeat_o[i] = 1'b0;
`endif
        assign bus.press_o[i]      = prs_q;
        assign bus.release_o[i]    = rel_q;
        assign bus.long_press_o[i] = lng_q;
        assign bus.held_o[i]       = (st_q != IDLE);
    end
endmodule

// File: tb/tb_button_events.sv
// tb_button_events: directed plus random button traffic checked against a hold-length model.
module tb_button_events;
    localparam int N = 4, LD = 8, RP = 4;
`ifdef BUTTON_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    button_events_if #(.N_BUTTONS(N)) bus ();
    button_events #(.N_BUTTONS(N), .LONG_DELAY(LD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;

    int total = 0, bad = 0;
    bit act [N];
    int k [N];
    logic [N-1:0] e_p, e_r, e_l, e_t, e_h;

    task automatic cmp(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s at %0t: observed=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    task automatic chk();
        cmp("press", bus.press_o, e_p);
        cmp("release", bus.release_o, e_r);
        cmp("long_press", bus.long_press_o, e_l);
        cmp("repeat", bus.repeat_o, e_t);
        cmp("held", bus.held_o, e_h);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0;
            k[i] = 0;
        end
        {e_p, e_r, e_l, e_t, e_h} = '0;
    endtask

    // k counts edges since the press edge; events derive from k directly.
    task automatic step(input logic [N-1:0] v);
        bus.in_i = v;
        @(posedge clk);
        {e_p, e_r, e_l, e_t} = '0;
        for (int i = 0; i < N; i++) begin
            if (!act[i] && v[i]) begin
                act[i] = 1'b1;
                k[i] = 0;
                e_p[i] = 1'b1;
            end else if (act[i] && !v[i]) begin
                act[i] = 1'b0;
                e_r[i] = 1'b1;
            end else if (act[i]) begin
                k[i]++;
                e_l[i] = (k[i] == LD);
                e_t[i] = REP && k[i] > LD && ((k[i] - LD) % RP == 0);
            end
            e_h[i] = act[i];
        end
        #1 chk();
    endtask

    initial begin
        logic [N-1:0] v;
        bus.in_i = 4'hF;
        model_reset();
        #12 chk();
        bus.in_i = 4'h1;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'h1);
        for (int j = 0; j < 19; j++) step(4'h1);
        step(4'h0);
        step(4'h0);
        for (int j = 0; j < 5; j++) step(4'h1);
        step(4'h0);
        step(4'h0);
        for (int j = 0; j < 8; j++) step(4'h2);
        step(4'h0);
        step(4'h0);
        step(4'h4);
        for (int j = 0; j < 12; j++) step(4'hC);
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk();
        bus.in_i = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'h0);
        step(4'h8);
        step(4'h0);
        step(4'h0);
        v = '0;
        for (int j = 0; j < 3000; j++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 11) == 0) v[i] = ~v[i];
            step(v);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
